// File: rtl/mul_pkg.sv
// Shared constants and state encoding for the sequential Booth multiplier.
package mul_pkg;

  localparam int unsigned MUL_W  = 16;
  localparam int unsigned DIGITS = 9;
  localparam int unsigned ACC_W  = 34;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned MLR_W  = MUL_W + 3;  // 18-bit extended multiplier plus appended 0

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/booth16.sv
// Radix-4 Booth digit encoder for a 16-bit multiplicand.
// {sign, adder} is the 18-bit partial product selection (0, +-a, +-2a), with
// negative digits delivered as the one's complement and neg=1 so the caller
// adds the +1 at the digit's bit 0.
module booth16
  import mul_pkg::*;
(
  input  logic [MUL_W-1:0] mcand,
  input  logic [2:0]       mlier,
  input  logic             umcand,
  output logic             sign,
  output logic [MUL_W:0]   adder,
  output logic             neg
);

  logic              ext;
  logic [MUL_W+1:0]  m1;
  logic [MUL_W+1:0]  m2;
  logic [MUL_W+1:0]  sel;

  // Select the digit multiple and apply one's-complement negation
  always_comb begin
    ext = umcand ? 1'b0 : mcand[MUL_W-1];
    m1  = {ext, ext, mcand};
    m2  = {ext, mcand, 1'b0};
    sel = '0;
    neg = 1'b0;
    case (mlier)
      3'b001, 3'b010: sel = m1;
      3'b011:         sel = m2;
      3'b100: begin   sel = ~m2; neg = 1'b1; end
      3'b101, 3'b110: begin sel = ~m1; neg = 1'b1; end
      default:        sel = '0;
    endcase
    sign  = sel[MUL_W+1];
    adder = sel[MUL_W:0];
  end

endmodule

// File: rtl/mul_booth_seq.sv
// Sequential radix-4 Booth multiplier, 16x16 -> 32, one digit per cycle.
// Optional early exit when the remaining multiplier digits are all zero:
// define MUL_SKIP_ZERO_EN.
module mul_booth_seq
  import mul_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MUL_W-1:0]   a,
  input  logic [MUL_W-1:0]   b,
  input  logic               a_unsigned,
  input  logic               b_unsigned,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*MUL_W-1:0] product,
  output logic               busy
);

  state_t            state_q, state_d;
  logic [MUL_W-1:0]  a_q, a_d;
  logic              au_q, au_d;
  logic [MLR_W-1:0]  mlier_q, mlier_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              bb_sign;
  logic [MUL_W:0]    bb_adder;
  logic              bb_neg;
  logic [ACC_W-1:0]  pp;
  logic [MLR_W-1:0]  mlier_sh;
  logic              last;
  logic              b_ext;

  booth16 u_booth16 (
    .mcand  (a_q),
    .mlier  (mlier_q[2:0]),
    .umcand (au_q),
    .sign   (bb_sign),
    .adder  (bb_adder),
    .neg    (bb_neg)
  );

  // Partial product, multiplier shift and digit-completion detection
  always_comb begin
    pp       = {{(ACC_W-MUL_W-2){bb_sign}}, bb_sign, bb_adder} + ACC_W'(bb_neg);
    mlier_sh = {{2{mlier_q[MLR_W-1]}}, mlier_q[MLR_W-1:2]};
    last     = (cnt_q == CNT_W'(DIGITS - 1));
`ifdef MUL_SKIP_ZERO_EN
    // Remaining bits all equal means every remaining digit selects zero
    if ((mlier_sh == '0) || (mlier_sh == '1)) last = 1'b1;
`endif
    b_ext    = b_unsigned ? 1'b0 : b[MUL_W-1];
  end

  // Next-state, datapath updates and handshake outputs
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    au_d      = au_q;
    mlier_d   = mlier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    product   = '0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          a_d     = a;
          au_d    = a_unsigned;
          mlier_d = {b_ext, b_ext, b, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        acc_d   = acc_q + (pp << {cnt_q, 1'b0});
        mlier_d = mlier_sh;
        cnt_d   = cnt_q + 1'b1;
        if (last) state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        product   = acc_q[2*MUL_W-1:0];
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      au_q    <= 1'b0;
      mlier_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      au_q    <= au_d;
      mlier_q <= mlier_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mul_booth_seq.sv
// Directed self-checking bench for mul_booth_seq.
`timescale 1ns/1ps
module tb_mul_booth_seq;

`ifdef MUL_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        a_unsigned;
  logic        b_unsigned;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  mul_booth_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .a_unsigned (a_unsigned),
    .b_unsigned (b_unsigned),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .product    (product),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Present operands in IDLE, return at the negedge of cycle 1
  task automatic start_op(input logic [15:0] av, input logic [15:0] bv,
                          input logic au, input logic bu);
    a = av; b = bv; a_unsigned = au; b_unsigned = bu;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count cycles from acceptance until out_valid, bounded
  task automatic wait_done(input string tag, output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_idle"}, {30'd0, in_ready, busy}, 32'd2);
  endtask

  task automatic do_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                       input logic au, input logic bu, input logic early,
                       input logic [31:0] exp, input int exp_lat);
    int lat;
    check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    out_ready = early;
    start_op(av, bv, au, bu);
    wait_done(tag, lat);
    if (exp_lat != 0) check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_prod"}, product, exp);
    finish_op(tag);
  endtask

  initial begin
    int lat;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; a_unsigned = 1'b0; b_unsigned = 1'b0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_state", {29'd0, in_ready, out_valid, busy}, 32'h4);
    check("rst_prod", product, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("uu_ffff",  16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b0, 32'hFFFE0001, SKIP ? 0 : 10);
    do_op("ss_ffff",  16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 32'h00000001, SKIP ? 0 : 10);
    do_op("ss_8000",  16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, 32'h40000000, SKIP ? 0 : 10);
    do_op("su_mix",   16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0, 32'hFFFF0001, SKIP ? 0 : 10);
    do_op("uu_1234",  16'h1234, 16'h5678, 1'b1, 1'b1, 1'b0, 32'h06260060, SKIP ? 0 : 10);
    do_op("us_8000",  16'h8000, 16'hFFFF, 1'b1, 1'b0, 1'b0, 32'hFFFF8000, SKIP ? 0 : 10);
    do_op("su_8000",  16'h8000, 16'hFFFF, 1'b0, 1'b1, 1'b1, 32'h80008000, SKIP ? 0 : 10);
    do_op("b3_early", 16'h0005, 16'h0003, 1'b0, 1'b0, 1'b0, 32'h0000000F, SKIP ? 3 : 10);
    do_op("bm1_early",16'h0007, 16'hFFFF, 1'b0, 1'b0, 1'b0, 32'hFFFFFFF9, SKIP ? 2 : 10);

    // Backpressure: product held while out_ready low, new operands ignored
    start_op(16'h1234, 16'h5678, 1'b1, 1'b1);
    wait_done("bp", lat);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_prod", product, 32'h06260060);
      check("bp_hold_flags", {30'd0, out_valid, in_ready}, 32'h2);
      a = 16'h0002; b = 16'h0003; a_unsigned = 1'b0; b_unsigned = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
    end
    check("bp_after_hold", product, 32'h06260060);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_reopen", {30'd0, in_ready, out_valid}, 32'h2);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_accepted", {31'd0, busy}, 32'd1);
    wait_done("bp_next", lat);
    check("bp_next_prod", product, 32'h00000006);
    finish_op("bp_next");

    // Reset mid-operation at BUSY cycle 4
    start_op(16'h1234, 16'h5678, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_flags", {29'd0, in_ready, out_valid, busy}, 32'h4);
    check("mid_rst_prod", product, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op("post_rst", 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0, 32'h00000006, SKIP ? 3 : 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
